egress_scheduler: RTL and testbench

- Downstream drain stage for the four per-class output FIFOs of the transaction layer.
- Pops those FIFOs by weighted round-robin and serialises the words onto one valid/ready egress stream with class tagging.
- Keeps per-class delivered-word counters, read back by index, so the bench can reconcile traffic against ingress.

---
 rtl/egress_pkg.sv | 19 +
 rtl/egress_rr_pick.sv | 28 ++
 rtl/egress_scheduler.sv | 145 ++++++++++++++
 tb/tb_egress_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_pkg.sv
// Shared types and constants for the egress scheduler: FSM encoding,
// class identifiers and the readback index of the total counter.
package egress_pkg;
  localparam int NUM_CLASS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [1:0] CLASS0 = 2'd0;
  localparam logic [1:0] CLASS1 = 2'd1;
  localparam logic [1:0] CLASS2 = 2'd2;
  localparam logic [1:0] CLASS3 = 2'd3;

  localparam logic [2:0] IDX_TOTAL = 3'd4;
endpackage

// File: rtl/egress_rr_pick.sv
// Rotate-priority picker: first non-empty class after rr_ptr (mod 4).
// Purely combinational, no backpressure.
module egress_rr_pick
  import egress_pkg::*;
(
  input  logic [3:0] empty,
  input  logic [1:0] rr_ptr,
  output logic [1:0] pick,
  output logic       any
);

  logic [1:0] w_cand;

  // Walk from furthest to nearest so the nearest non-empty class wins.
  always_comb begin
    pick   = CLASS0;
    any    = 1'b0;
    w_cand = CLASS0;
    for (int k = NUM_CLASS; k >= 1; k--) begin
      w_cand = rr_ptr + 2'(k);
      if (!empty[w_cand]) begin
        pick = w_cand;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_scheduler.sv
// Weighted round-robin drain of four class FIFOs onto one tagged valid/ready stream.
// Empty-to-valid 3 cycles, one word per 3 cycles; no pop while a word waits for out_ready.
module egress_scheduler
  import egress_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int NUM_CLASS = egress_pkg::NUM_CLASS,
  parameter int WEIGHT_W  = 3,
  parameter int CNT_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          empty,
  input  logic [DATA_W-1:0]   data_in0,
  input  logic [DATA_W-1:0]   data_in1,
  input  logic [DATA_W-1:0]   data_in2,
  input  logic [DATA_W-1:0]   data_in3,
  output logic [3:0]          pop,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_class,
  input  logic [2:0]          idx,
  output logic [CNT_W-1:0]    count,
  output logic                count_valid,
  output logic                idle
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic [1:0]          r_grant;
  logic [1:0]          r_rr;
  logic [WEIGHT_W-1:0] r_burst;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [1:0]          r_out_class;
  logic                r_idle;
  logic [CNT_W-1:0]    r_cnt [NUM_CLASS];
  logic [CNT_W-1:0]    r_total;

  logic [1:0]          w_pick;
  logic                w_any;
  logic                w_hs;
  logic [DATA_W-1:0]   w_data   [NUM_CLASS];
  logic [WEIGHT_W-1:0] w_weight [NUM_CLASS];

  assign w_data[0]   = data_in0;
  assign w_data[1]   = data_in1;
  assign w_data[2]   = data_in2;
  assign w_data[3]   = data_in3;
  assign w_weight[0] = weight0;
  assign w_weight[1] = weight1;
  assign w_weight[2] = weight2;
  assign w_weight[3] = weight3;

  egress_rr_pick u_pick (
    .empty  (empty),
    .rr_ptr (r_rr),
    .pick   (w_pick),
    .any    (w_any)
  );

  // The pop is withdrawn if the granted FIFO drains between grant and issue.
  assign pop = (r_state == ISSUE && !empty[r_grant]) ? (4'b0001 << r_grant) : 4'b0000;
  assign w_hs        = r_out_valid & out_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_class   = r_out_class;
  assign idle        = r_idle;
  assign count_valid = r_idle & (idx <= IDX_TOTAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= CLASS0;
      r_rr        <= CLASS3;
      r_burst     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_class <= CLASS0;
      r_idle      <= 1'b0;
    end else begin
      r_idle <= (r_state == IDLE) && (empty == 4'b1111) && !r_out_valid;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_burst <= (w_weight[w_pick] == '0) ? WEIGHT_W'(1) : w_weight[w_pick];
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (empty[r_grant]) begin
            r_rr    <= r_grant;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_out_data  <= w_data[r_grant];
          r_out_class <= r_grant;
          r_out_valid <= 1'b1;
          r_burst     <= r_burst - WEIGHT_W'(1);
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_burst != '0 && !empty[r_grant]) begin
              r_state <= ISSUE;
            end else begin
              r_rr    <= r_grant;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Delivered-word counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_CLASS; n++) r_cnt[n] <= '0;
      r_total <= '0;
    end else if (w_hs) begin
      if (r_cnt[r_out_class] != CNT_MAX) r_cnt[r_out_class] <= r_cnt[r_out_class] + CNT_W'(1);
      if (r_total != CNT_MAX) r_total <= r_total + CNT_W'(1);
    end
  end

  always_comb begin
    count = '0;
    if (idx == IDX_TOTAL) count = r_total;
    else if (!idx[2])     count = r_cnt[idx[1:0]];
  end

endmodule

// File: tb/tb_egress_scheduler.sv
// Directed bench for egress_scheduler: FIFO model feeds the DUT, a scoreboard
// queue holds hand-ordered expected words and a monitor checks every handshake.
module tb_egress_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  empty;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]  pop;
  logic [2:0]  weight0, weight1, weight2, weight3;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic [1:0]  out_class;
  logic [2:0]  idx;
  logic [4:0]  count;
  logic        count_valid;
  logic        idle;

  always #5 clk = ~clk;

  egress_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .data_in0    (data_in0),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .data_in3    (data_in3),
    .pop         (pop),
    .weight0     (weight0),
    .weight1     (weight1),
    .weight2     (weight2),
    .weight3     (weight3),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_class   (out_class),
    .idx         (idx),
    .count       (count),
    .count_valid (count_valid),
    .idle        (idle)
  );

  // FIFO model: read data appears the cycle after a pop.
  logic [11:0] mem [4][64];
  int          wr  [4];
  int          rd  [4];
  logic [3:0]  mask;
  logic [11:0] dq  [4];

  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) rd[n] <= 0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (pop[n]) begin
          dq[n] <= mem[n][rd[n]];
          rd[n] <= rd[n] + 1;
        end
      end
    end
  end

  always_comb begin
    empty = 4'b0000;
    for (int n = 0; n < 4; n++) empty[n] = mask[n] | (wr[n] == rd[n]);
  end

  assign data_in0 = dq[0];
  assign data_in1 = dq[1];
  assign data_in2 = dq[2];
  assign data_in3 = dq[3];

  typedef struct packed {
    logic [1:0]  cls;
    logic [11:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cls_seq [8] = '{0, 0, 1, 0, 0, 1, 1, 1};
  int   n0, n1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fifo_put(input int c, input logic [11:0] d);
    mem[c][wr[c]] = d;
    wr[c] = wr[c] + 1;
  endtask

  task automatic sb_expect(input int c, input logic [11:0] d);
    exp_t x;
    x.cls = c[1:0];
    x.dat = d;
    sb.push_back(x);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) wr[n] = 0;
    mask = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (!(idle && sb.size() == 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s: not idle after %0d cycles, %0d words outstanding", nm, k, sb.size());
    end
  endtask

  task automatic read_cnt(input logic [2:0] sel, input logic [4:0] exp, input string nm);
    idx = sel;
    #1;
    chk(nm, count, exp);
  endtask

  // Monitor: samples well after the falling edge so stimulus changes have settled.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("pop_onehot0", 32'($onehot0(pop)), 32'd1);
      if (out_valid) chk("pop_during_valid", pop, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got class %0d data 0x%0h, expected none", out_class, out_data);
        end else begin
          e = sb.pop_front();
          chk("word_class", out_class, e.cls);
          chk("word_data", out_data, e.dat);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    idx = 3'd0;
    weight0 = 3'd0; weight1 = 3'd0; weight2 = 3'd0; weight3 = 3'd0;
    for (int n = 0; n < 4; n++) dq[n] = 12'h000;
    hold_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pop", pop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_count", count, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_idle", idle, 0);

    // Single word through class 2
    fifo_put(2, 12'h8A5);
    sb_expect(2, 12'h8A5);
    reset = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t1_pop_c%0d", c), pop, (c == 2) ? 4'b0100 : 4'b0000);
      chk($sformatf("t1_valid_c%0d", c), out_valid, (c == 4) ? 1 : 0);
      if (c == 4) begin
        chk("t1_data", out_data, 12'h8A5);
        chk("t1_class", out_class, 2);
      end
    end
    repeat (3) @(negedge clk);
    read_cnt(3'd2, 5'd1, "t1_cnt2");
    chk("t1_count_valid", count_valid, 1);
    read_cnt(3'd4, 5'd1, "t1_total");

    // Weighted round-robin: weight0=2, weight1=1
    hold_reset();
    weight0 = 3'd2;
    weight1 = 3'd1;
    for (int i = 0; i < 4; i++) begin
      fifo_put(0, 12'hA00 + 12'(i));
      fifo_put(1, 12'hB00 + 12'(i));
    end
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (cls_seq[i] == 0) begin
        sb_expect(0, 12'hA00 + 12'(n0));
        n0++;
      end else begin
        sb_expect(1, 12'hB00 + 12'(n1));
        n1++;
      end
    end
    reset = 1'b0;
    wait_idle(100, "t2_done");
    read_cnt(3'd0, 5'd4, "t2_cnt0");
    read_cnt(3'd1, 5'd4, "t2_cnt1");
    read_cnt(3'd4, 5'd8, "t2_total");

    // Backpressure with a second class waiting
    hold_reset();
    weight0 = 3'd1;
    out_ready = 1'b0;
    fifo_put(0, 12'h3C3);
    sb_expect(0, 12'h3C3);
    fifo_put(1, 12'h5A5);
    sb_expect(1, 12'h5A5);
    reset = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    #1;
    chk("t3_valid_rise", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 12'h3C3);
      chk("t3_hold_pop", pop, 0);
    end
    read_cnt(3'd0, 5'd0, "t3_cnt0_before");
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle(50, "t3_done");
    read_cnt(3'd0, 5'd1, "t3_cnt0_after");
    read_cnt(3'd4, 5'd2, "t3_total");

    // Empty race on class 3 during ISSUE
    hold_reset();
    weight0 = 3'd0; weight1 = 3'd0;
    fifo_put(1, 12'h111);
    sb_expect(1, 12'h111);
    reset = 1'b0;
    wait_idle(30, "t4_first");
    fifo_put(3, 12'h333);
    @(negedge clk);
    mask[3] = 1'b1;
    #1;
    chk("t4_race_pop", pop, 0);
    @(negedge clk);
    #1;
    chk("t4_race_valid", out_valid, 0);
    fifo_put(0, 12'hA0A);
    sb_expect(0, 12'hA0A);
    fifo_put(2, 12'h2B2);
    sb_expect(2, 12'h2B2);
    wait_idle(40, "t4_after_race");
    mask[3] = 1'b0;
    sb_expect(3, 12'h333);
    wait_idle(40, "t4_class3");
    read_cnt(3'd3, 5'd1, "t4_cnt3");
    read_cnt(3'd4, 5'd4, "t4_total");

    // Saturation on class 1
    hold_reset();
    weight1 = 3'd7;
    for (int i = 0; i < 40; i++) begin
      fifo_put(1, 12'h400 + 12'(i));
      sb_expect(1, 12'h400 + 12'(i));
    end
    reset = 1'b0;
    wait_idle(400, "t5_done");
    read_cnt(3'd1, 5'd31, "t5_cnt1");
    chk("t5_count_valid1", count_valid, 1);
    read_cnt(3'd4, 5'd31, "t5_total");
    read_cnt(3'd6, 5'd0, "t5_idx6");
    chk("t5_count_valid6", count_valid, 0);

    // Reset while a popped word sits in WAIT
    fifo_put(2, 12'hDEF);
    @(negedge clk);
    #1;
    chk("t6_issue_pop", pop, 4'b0100);
    @(negedge clk);
    #1;
    chk("t6_wait_valid", out_valid, 0);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) wr[n] = 0;
    @(negedge clk);
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_pop", pop, 0);
    for (int s = 0; s <= 4; s++) read_cnt(3'(s), 5'd0, $sformatf("t6_cnt%0d", s));
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_replay", out_valid, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
